clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. Generalises the fixed even-only and odd-only dividers into one block with a divisor loaded at run time.
- Divisor changes are glitch-free and take effect only at period boundaries. Enable/stop is clean and also boundary-aligned.
- Provides a one-cycle tick strobe alongside the divided clock, for logic that stays on clk_ref.
- Sits in the common clocking library; feeds peripheral and bus-rate clocks.

Parameters:
- WIDTH, 8, width of the divisor; legal divisor range is 2..2^WIDTH-1.
- DIV_RESET, 4, divisor value loaded at reset; must be 2 or greater.

Ports:
- clk_ref  in  1  reference clock; all state is on the rising edge, except the optional negedge flop.
- srst  in  1  synchronous active-high reset.
- en  in  1  run request.
- div_in  in  WIDTH  new divisor value.
- div_load  in  1  one-cycle strobe that captures div_in.
- div_pending  out  1  a loaded divisor is waiting for a period boundary.
- div_ack  out  1  one-cycle pulse on the edge where the new divisor is applied.
- div_err  out  1  one-cycle pulse when div_load carries div_in < 2.
- div_cur  out  WIDTH  divisor currently in force (N).
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse coincident with each rising edge of clk_out.

Behaviour:
- Clock and reset: one clock, clk_ref. srst is synchronous and active-high.
- Reset values (srst=1 at an edge):
  - state=IDLE, cnt=DIV_RESET-1, N=DIV_RESET.
  - clk_out=0, tick=0, div_pending=0, div_ack=0, div_err=0.
  - Any pending divisor is discarded.
  - srst mid-period truncates the output immediately: clk_out is 0 after that edge.
- Counter:
  - cnt runs 0..N-1 and wraps at N-1.
  - H = N>>1.
  - On every counting edge: clk_out <= (cnt_next < H) and tick <= (cnt_next == 0).
  - Even N gives exactly 50% duty.
  - Odd N gives H high cycles and N-H low cycles (unless the optional feature is enabled).
- State machine:
  - IDLE: cnt holds N-1, clk_out=0, tick=0. en=1 → RUN. The first RUN edge gives cnt=0, clk_out=1, tick=1 (latency 1 clk_ref cycle from the edge that samples en=1).
  - RUN: counts. If en=0 at an edge where cnt==N-1 → IDLE. If en=0 at any other edge → STOP.
  - STOP: keeps counting so the current period completes. en=1 → RUN with no phase disturbance. At the cnt==N-1 edge → IDLE; no new period starts.
- Divisor load:
  - div_load with div_in >= 2 latches div_in into the pending register and sets div_pending=1.
  - A repeated load while pending overwrites the pending value; only the last one applies.
  - div_load with div_in < 2: div_err pulses; pending register and N are unchanged.
- Divisor apply:
  - In RUN/STOP, the pending value is applied at the wrap edge (cnt==N-1 → 0). cnt_next=0, H is computed from the new N, div_cur updates, div_ack pulses, div_pending clears.
  - In IDLE, the pending value is applied on the next edge and cnt is set to newN-1.
  - A div_load on the same edge as the apply boundary is not applied on that edge; it applies at the next boundary.
- Simultaneous events:
  - srst overrides everything.
  - en falling on the wrap edge with a divisor pending: the divisor is applied and the state goes to IDLE.
- Glitch-freedom: clk_out never shows a high or low phase shorter than min(H, N-H) of the old or new N.

Optional Feature:
- Macro: CLK_DIV_PROG_ODD_DUTY50_EN.
- Defined:
  - Adds a falling-edge flop neg_q <= pos_q, reset to 0 by srst (sampled on the falling edge).
  - clk_out = pos_q | (neg_q & N[0]). For odd N the high phase is extended by half a cycle, giving exactly N/2 high, i.e. 50% duty.
  - Even N is unchanged.
  - tick is unaffected.
- Undefined: no negedge logic. Odd N duty is H/N, and clk_out is driven purely from a posedge flop.

Test Plan:
- Reset then enable: DIV_RESET=4, srst pulse, en=1 → tick every 4 cycles; clk_out pattern 1100 repeating; first tick one cycle after en is sampled.
- Odd divisor: load 5 while running → div_ack exactly at the wrap; then clk_out pattern 11000. With the macro defined, clk_out is high for 2.5 clk_ref periods.
- Pending overwrite and error: load 6 then 3 before the boundary → only 3 applied, one div_ack. Load 1 → div_err pulses; div_cur unchanged.
- Clean stop: N=6, drop en at cnt=1 → period completes (3 high, 3 low), IDLE with clk_out=0. Re-raise en during STOP → output continues uninterrupted.
- Reset mid-operation: srst at cnt=2 with a divisor pending → clk_out=0 next edge, div_cur=DIV_RESET, div_pending=0, no div_ack.
- Max divisor: WIDTH=8, load 255 → 127 high / 128 low; cnt wraps 254 → 0 with no overflow.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with boundary-aligned divisor changes and enable.
// Optional macro CLK_DIV_PROG_ODD_DUTY50_EN adds a falling-edge flop for 50% duty on odd divisors.
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             clk_ref,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  localparam logic [WIDTH-1:0] N_RST   = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DIV_RESET - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             at_wrap;
  logic             apply;
  logic [WIDTH-1:0] n_new;
  logic [WIDTH-1:0] h_new;
  logic [WIDTH-1:0] cnt_inc;

  // A pending divisor lands either at the wrap edge or on any edge spent in IDLE.
  assign at_wrap = (cnt_q == (n_q - ONE));
  assign apply   = pend_q && ((state_q == IDLE) || at_wrap);
  assign n_new   = apply ? pval_q : n_q;
  assign h_new   = n_new >> 1;
  assign cnt_inc = at_wrap ? '0 : (cnt_q + ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    pos_d   = pos_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    if (apply) begin
      n_d    = n_new;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end

    // A load on the apply edge only refills the pending slot for the next boundary.
    if (div_load) begin
      if (div_in < TWO) begin
        err_d = 1'b1;
      end else begin
        pval_d = div_in;
        pend_d = 1'b1;
      end
    end

    case (state_q)
      RUN, STOP: begin
        if (!en && at_wrap) begin
          state_d = IDLE;
          cnt_d   = n_new - ONE;
          pos_d   = 1'b0;
        end else begin
          state_d = en ? RUN : STOP;
          cnt_d   = cnt_inc;
          pos_d   = (cnt_inc < h_new);
          tick_d  = (cnt_inc == '0);
        end
      end
      default: begin
        cnt_d = n_new - ONE;
        pos_d = 1'b0;
        if (en) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_RST;
      n_q     <= N_RST;
      pend_q  <= 1'b0;
      pos_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // The pending value is only meaningful while pend_q is set.
  always_ff @(posedge clk_ref) begin
    pval_q <= pval_d;
  end

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
  logic neg_q;

  always_ff @(negedge clk_ref) begin
    if (srst) neg_q <= 1'b0;
    else      neg_q <= pos_q;
  end

  assign clk_out = pos_q | (neg_q & n_q[0]);
`else
  assign clk_out = pos_q;
`endif

  assign tick        = tick_q;
  assign div_pending = pend_q;
  assign div_ack     = ack_q;
  assign div_err     = err_q;
  assign div_cur     = n_q;

endmodule
